// File: rtl/mc_resp_model.sv
// mc_resp_model
// Behavioural memory-controller responder for the MC request/response interface.
// Requests are queued, held for a fixed service latency, then executed against a
// local 64-bit word array; responses come back strictly in request order with
// scmd and rtnctl echoed.
// Build option: define MC_RESP_RANDLAT_EN to add 0..7 LFSR-chosen extra cycles
// of latency per request (ordering is unaffected). Undefined = fixed latency.
module mc_resp_model #(
   parameter int MC_RTNCTL_WIDTH = 32,
   parameter int MEM_WORDS       = 256,
   parameter int FIFO_DEPTH      = 8,
   parameter int LATENCY         = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       mc_rq_vld,
   input  logic [2:0]                 mc_rq_cmd,
   input  logic [3:0]                 mc_rq_scmd,
   input  logic [47:0]                mc_rq_vadr,
   input  logic [1:0]                 mc_rq_size,
   input  logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
   input  logic [63:0]                mc_rq_data,
   input  logic                       mc_rq_flush,
   output logic                       mc_rq_stall,
   output logic                       mc_rs_vld,
   output logic [2:0]                 mc_rs_cmd,
   output logic [3:0]                 mc_rs_scmd,
   output logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
   output logic [63:0]                mc_rs_data,
   input  logic                       mc_rs_stall,
   output logic                       err_sticky
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] STALL_C = CNT_W'(FIFO_DEPTH - 2);
   localparam logic [16:0]      LAT_C   = 17'(LATENCY);

   // queued request kinds
   localparam logic [1:0] TY_RD = 2'd0;
   localparam logic [1:0] TY_WR = 2'd1;
   localparam logic [1:0] TY_FL = 2'd2;
   localparam logic [1:0] TY_IL = 2'd3;

   // response command codes
   localparam logic [2:0] RS_RD_DATA  = 3'd2;
   localparam logic [2:0] RS_WR_CMPLT = 3'd3;
   localparam logic [2:0] RS_FLUSH    = 3'd4;
   localparam logic [2:0] RS_ERR      = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_PRESENT = 2'd2
   } state_t;

   // Merge 2^size bytes of wdata (from byte 0 upward) into old_w starting at
   // byte lane 'lane'. Bytes that would land past lane 7 are dropped.
   function automatic logic [63:0] byte_merge(
      input logic [63:0] old_w,
      input logic [63:0] wdata,
      input logic [2:0]  lane,
      input logic [1:0]  size
   );
      logic [63:0] res;
      logic [63:0] shifted;
      logic [3:0]  nbytes;
      logic [3:0]  lo;
      logic [3:0]  hi;
      res     = old_w;
      shifted = wdata << {lane, 3'b000};
      nbytes  = 4'd1 << size;
      lo      = {1'b0, lane};
      hi      = lo + nbytes;
      for (int b = 0; b < 8; b++) begin
         if ((4'(b) >= lo) && (4'(b) < hi)) begin
            res[b*8 +: 8] = shifted[b*8 +: 8];
         end
      end
      return res;
   endfunction

   // request queue storage
   logic [1:0]                 q_type_r   [FIFO_DEPTH];
   logic [3:0]                 q_scmd_r   [FIFO_DEPTH];
   logic [IDX_W-1:0]           q_idx_r    [FIFO_DEPTH];
   logic [2:0]                 q_lane_r   [FIFO_DEPTH];
   logic [1:0]                 q_size_r   [FIFO_DEPTH];
   logic [MC_RTNCTL_WIDTH-1:0] q_rtnctl_r [FIFO_DEPTH];
   logic [63:0]                q_data_r   [FIFO_DEPTH];
   logic [15:0]                q_stamp_r  [FIFO_DEPTH];

   logic [63:0]                mem_r [MEM_WORDS];

   logic [PTR_W-1:0]           wr_ptr_r;
   logic [PTR_W-1:0]           rd_ptr_r;
   logic [CNT_W-1:0]           count_r;
   logic [CNT_W-1:0]           count_nxt_s;
   logic [15:0]                cnt_r;

   state_t                     state_r;
   state_t                     state_nxt_s;

   logic                       full_s;
   logic                       push_s;
   logic                       drop_s;
   logic                       pop_s;
   logic                       xfer_s;
   logic                       enter_wait_s;
   logic [1:0]                 rq_type_s;

   logic [1:0]                 hd_type_s;
   logic [IDX_W-1:0]           hd_idx_s;
   logic [15:0]                age_s;
   logic                       lat_ok_s;
   logic [2:0]                 extra_s;
   logic [63:0]                merged_s;

   logic                       rq_stall_r;
   logic                       rs_vld_r;
   logic [2:0]                 rs_cmd_r;
   logic [3:0]                 rs_scmd_r;
   logic [MC_RTNCTL_WIDTH-1:0] rs_rtnctl_r;
   logic [63:0]                rs_data_r;
   logic                       err_r;

   // address bits above the word index alias onto the same word
   logic                       unused_vadr_s;
   assign unused_vadr_s = ^mc_rq_vadr[47:3+IDX_W];

   assign full_s   = (count_r == DEPTH_C);
   assign push_s   = mc_rq_vld && !full_s;
   assign drop_s   = mc_rq_vld && full_s;

   assign hd_type_s = q_type_r[rd_ptr_r];
   assign hd_idx_s  = q_idx_r[rd_ptr_r];
   assign merged_s  = byte_merge(mem_r[hd_idx_s], q_data_r[rd_ptr_r],
                                 q_lane_r[rd_ptr_r], q_size_r[rd_ptr_r]);

   // wrap-safe age of the head entry against the free-running cycle count
   assign age_s    = cnt_r - q_stamp_r[rd_ptr_r];
   assign lat_ok_s = ({1'b0, age_s} >= (LAT_C + {14'd0, extra_s}));

   // classify the incoming request; flush overrides cmd
   always_comb begin
      rq_type_s = TY_IL;
      if (mc_rq_flush) begin
         rq_type_s = TY_FL;
      end else begin
         case (mc_rq_cmd)
            3'd1:    rq_type_s = TY_RD;
            3'd2:    rq_type_s = TY_WR;
            default: rq_type_s = TY_IL;
         endcase
      end
   end

   // next occupancy: simultaneous push and pop leave the count unchanged
   always_comb begin
      count_nxt_s = count_r;
      if (push_s && !pop_s) begin
         count_nxt_s = count_r + CNT_W'(1);
      end else if (pop_s && !push_s) begin
         count_nxt_s = count_r - CNT_W'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // queue entry capture; stamp is the cycle count as of the accepting edge
   always_ff @(posedge clk) begin
      if (push_s) begin
         q_type_r[wr_ptr_r]   <= rq_type_s;
         q_scmd_r[wr_ptr_r]   <= mc_rq_scmd;
         q_idx_r[wr_ptr_r]    <= mc_rq_vadr[3 +: IDX_W];
         q_lane_r[wr_ptr_r]   <= mc_rq_vadr[2:0];
         q_size_r[wr_ptr_r]   <= mc_rq_size;
         q_rtnctl_r[wr_ptr_r] <= mc_rq_rtnctl;
         q_data_r[wr_ptr_r]   <= mc_rq_data;
         q_stamp_r[wr_ptr_r]  <= cnt_r + 16'd1;
      end
   end

   // queue pointers, occupancy, cycle counter and registered backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= {CNT_W{1'b0}};
         cnt_r      <= 16'd0;
         rq_stall_r <= 1'b0;
      end else begin
         cnt_r      <= cnt_r + 16'd1;
         count_r    <= count_nxt_s;
         rq_stall_r <= (count_nxt_s >= STALL_C);
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
      end
   end

   // output FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // output FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (count_r != {CNT_W{1'b0}}) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (lat_ok_s) begin
               state_nxt_s = ST_PRESENT;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_PRESENT: begin
            if (!mc_rs_stall) begin
               if (count_r != {CNT_W{1'b0}}) begin
                  state_nxt_s = ST_WAIT;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else begin
               state_nxt_s = ST_PRESENT;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // output FSM control strobes
   always_comb begin
      pop_s        = 1'b0;
      xfer_s       = 1'b0;
      enter_wait_s = 1'b0;
      if (state_r == ST_WAIT) begin
         pop_s = lat_ok_s;
      end else begin
         pop_s = 1'b0;
      end
      if (state_r == ST_PRESENT) begin
         xfer_s = !mc_rs_stall;
      end else begin
         xfer_s = 1'b0;
      end
      if ((state_nxt_s == ST_WAIT) && (state_r != ST_WAIT)) begin
         enter_wait_s = 1'b1;
      end else begin
         enter_wait_s = 1'b0;
      end
   end

`ifdef MC_RESP_RANDLAT_EN
   logic [15:0] lfsr_r;
   logic [2:0]  extra_r;

   // LFSR x^16+x^14+x^13+x^11+1 advances per pop; extra delay sampled on WAIT entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_r  <= 16'hACE1;
         extra_r <= 3'd0;
      end else begin
         if (pop_s) begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
         end
         if (enter_wait_s) begin
            extra_r <= lfsr_r[2:0];
         end
      end
   end

   assign extra_s = extra_r;
`else
   logic unused_enter_wait_s;
   assign unused_enter_wait_s = enter_wait_s;
   assign extra_s = 3'd0;
`endif

   // array write at pop; pop is forced low while reset holds the FSM idle
   always_ff @(posedge clk) begin
      if (pop_s && (hd_type_s == TY_WR)) begin
         mem_r[hd_idx_s] <= merged_s;
      end
   end

   // response register: loaded at pop, held while stalled, cleared on transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs_vld_r    <= 1'b0;
         rs_cmd_r    <= 3'd0;
         rs_scmd_r   <= 4'd0;
         rs_rtnctl_r <= {MC_RTNCTL_WIDTH{1'b0}};
         rs_data_r   <= 64'd0;
      end else if (pop_s) begin
         rs_vld_r    <= 1'b1;
         rs_scmd_r   <= q_scmd_r[rd_ptr_r];
         rs_rtnctl_r <= q_rtnctl_r[rd_ptr_r];
         case (hd_type_s)
            TY_RD: begin
               rs_cmd_r  <= RS_RD_DATA;
               rs_data_r <= mem_r[hd_idx_s];
            end
            TY_WR: begin
               rs_cmd_r  <= RS_WR_CMPLT;
               rs_data_r <= 64'd0;
            end
            TY_FL: begin
               rs_cmd_r  <= RS_FLUSH;
               rs_data_r <= 64'd0;
            end
            default: begin
               rs_cmd_r  <= RS_ERR;
               rs_data_r <= 64'd0;
            end
         endcase
      end else if (xfer_s) begin
         rs_vld_r <= 1'b0;
      end
   end

   // sticky error: queue overflow drop or illegal command reaching the head
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_r <= 1'b0;
      end else if (drop_s || (pop_s && (hd_type_s == TY_IL))) begin
         err_r <= 1'b1;
      end
   end

   assign mc_rq_stall  = rq_stall_r;
   assign mc_rs_vld    = rs_vld_r;
   assign mc_rs_cmd    = rs_cmd_r;
   assign mc_rs_scmd   = rs_scmd_r;
   assign mc_rs_rtnctl = rs_rtnctl_r;
   assign mc_rs_data   = rs_data_r;
   assign err_sticky   = err_r;

endmodule
